mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter sharing the single-port devices SRAM (sram0) between the MIPS core (master 0) and a second bus master (master 1), such as a loader or DMA.
- Sits between the masters and the SRAM inside top.
- Round-robin ownership with optional locked bursts, bounded by MAX_BURST to prevent starvation.
- Converts byte addresses to SRAM word addresses.

Parameters:
- WIDTH, 32, data and byte-address width.
- SRAM_AW, 8, SRAM word-address width; sram_adr = adr[SRAM_AW+1:2].
- MAX_BURST, 4, maximum locked transfers per tenure while the other master waits (≥1).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request; held with adr/we/wdata stable until granted.
- m0_lock  in  1  master 0 requests to keep ownership after the current transfer.
- m0_we  in  1  1 = write, 0 = read.
- m0_adr  in  WIDTH  byte address.
- m0_wdata  in  WIDTH  write data.
- m0_gnt  out  1  ownership; transfer occurs in any cycle with m0_req & m0_gnt.
- m0_rvalid  out  1  read data valid on rdata.
- m1_req, m1_lock, m1_we, m1_adr, m1_wdata, m1_gnt, m1_rvalid: same as master 0.
- rdata  out  WIDTH  shared read data, equal to sram_rdata.
- sram_cs  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write enable.
- sram_adr  out  SRAM_AW  SRAM word address.
- sram_wdata  out  WIDTH  SRAM write data.
- sram_rdata  in  WIDTH  SRAM read data, valid one cycle after a read strobe.
- owner  out  2  debug: 00 idle, 01 m0, 10 m1.

Behaviour:
- Reset (async, reset_=0):
  - state=IDLE; gnt, rvalid, sram_cs, sram_we all 0; owner=00; bcnt=0; last=1 (m0 wins the first tie).
  - Any in-flight read is discarded; no rvalid follows reset.
- States: IDLE, OWN0, OWN1. State and last are registered.
  - gnt_x = (state==OWNx), registered, so gnt is low in the cycle req first rises.
  - Minimum request-to-grant latency: 1 cycle.
- IDLE transitions:
  - both req → OWN of the master ≠ last.
  - only req0 → OWN0; only req1 → OWN1.
  - none → IDLE.
- SRAM drive in OWNx:
  - sram_cs = req_x; sram_we = req_x & we_x; sram_adr = adr_x[SRAM_AW+1:2]; sram_wdata = wdata_x.
  - In IDLE: sram_cs = 0, sram_we = 0; address and data are don't-care but hold the last value.
- Read return: rvalid_x registered to (req_x & gnt_x & ~we_x), so it pulses exactly 1 cycle after the read transfer; rdata = sram_rdata in that cycle.
- bcnt:
  - Cleared on entry to any OWN state.
  - Incremented per transfer; saturates at MAX_BURST.
- Release from OWNx at an edge when any of:
  - ~req_x;
  - req_x & ~lock_x (a transfer just occurred);
  - bcnt == MAX_BURST-1 with a transfer this cycle and req of the other master high.
- On release:
  - last ← x.
  - Next state: OWN_other if the other master requests; else OWNx (bcnt=0) if req_x is still high; else IDLE.
  - Switching OWN0 → OWN1 takes no idle cycle.
- No release: stay OWNx. A locked master with no competitor may exceed MAX_BURST indefinitely.
- Simultaneous events:
  - A req rising on the same edge as the current owner's release is seen in that release decision.
  - A master dropping req while granted causes no transfer; the arbiter releases at the next edge.
- Write-through: writes commit at the SRAM on the transfer cycle's posedge; rvalid is never asserted for writes.
- An unaligned adr[1:0] is ignored (word access).

Test Plan:
- m0 read at adr 0x14, SRAM word 5 = 0x20070005 → gnt on cycle 1; sram_cs=1, sram_we=0, sram_adr=5; m0_rvalid=1 with rdata=0x20070005 on cycle 2.
- m0 write adr=20, wdata=7 → sram_adr=5, sram_we=1, sram_wdata=7 for exactly one cycle; m0_rvalid stays 0.
- Both req (no lock) from reset → grants alternate m0, m1, m0, m1 on consecutive cycles with no idle gap; owner toggles 01/10.
- m1 lock=1 for 10 reads, m0 req held, MAX_BURST=4 → exactly 4 m1 transfers, then m0_gnt next cycle; m1 regains ownership after m0 releases.
- m0 lock=1 alone for 8 transfers → m0_gnt continuous for 8 cycles (no MAX_BURST release without a competitor); IDLE after req drops.
- reset_ pulsed low mid-burst with a read outstanding → gnt, sram_cs, rvalid go 0 immediately (asynchronously); no rvalid after release; first post-reset tie granted to m0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared single-port SRAM.
// The slave modport is the arbiter's view; the master modport is the masters'/SRAM side.
interface mem_arbiter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SRAM_AW = 8
);
    logic               m0_req;
    logic               m0_lock;
    logic               m0_we;
    logic [WIDTH-1:0]   m0_adr;
    logic [WIDTH-1:0]   m0_wdata;
    logic               m0_gnt;
    logic               m0_rvalid;

    logic               m1_req;
    logic               m1_lock;
    logic               m1_we;
    logic [WIDTH-1:0]   m1_adr;
    logic [WIDTH-1:0]   m1_wdata;
    logic               m1_gnt;
    logic               m1_rvalid;

    logic [WIDTH-1:0]   rdata;
    logic [1:0]         owner;

    logic               sram_cs;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_adr;
    logic [WIDTH-1:0]   sram_wdata;
    logic [WIDTH-1:0]   sram_rdata;

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_adr, m0_wdata,
        output m0_gnt, m0_rvalid,
        input  m1_req, m1_lock, m1_we, m1_adr, m1_wdata,
        output m1_gnt, m1_rvalid,
        output rdata, owner,
        output sram_cs, sram_we, sram_adr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output m0_req, m0_lock, m0_we, m0_adr, m0_wdata,
        input  m0_gnt, m0_rvalid,
        output m1_req, m1_lock, m1_we, m1_adr, m1_wdata,
        input  m1_gnt, m1_rvalid,
        input  rdata, owner,
        input  sram_cs, sram_we, sram_adr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-port SRAM, with locked bursts capped at
// MAX_BURST while the other master waits. Byte addresses are mapped to SRAM word addresses.
module mem_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SRAM_AW   = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input logic         clk,
    input logic         reset_,
    mem_arbiter_if.slave bus
);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BurstMax  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BurstLast = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;     // 0: m0 owned last, 1: m1 owned last
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               gnt0_q, gnt1_q;
    logic               rvalid0_q, rvalid1_q;
    logic [1:0]         owner_q;
    logic [SRAM_AW-1:0] adr_hold_q;
    logic [WIDTH-1:0]   wdata_hold_q;

    logic               xfer0, xfer1;
    logic               rel;
    logic               sram_cs, sram_we;
    logic [SRAM_AW-1:0] sram_adr;
    logic [WIDTH-1:0]   sram_wdata;

    assign xfer0 = bus.m0_req & gnt0_q;
    assign xfer1 = bus.m1_req & gnt1_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        rel     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (bus.m0_req) begin
                    state_d = StOwn0;
                end else if (bus.m1_req) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (xfer0 && bcnt_q != BurstMax) bcnt_d = bcnt_q + 1'b1;
                // >= so a count that saturated without a competitor still yields later
                rel = ~bus.m0_req | ~bus.m0_lock | (bcnt_q >= BurstLast & xfer0 & bus.m1_req);
                if (rel) begin
                    last_d  = 1'b0;
                    state_d = bus.m1_req ? StOwn1 : (bus.m0_req ? StOwn0 : StIdle);
                end
            end
            StOwn1: begin
                if (xfer1 && bcnt_q != BurstMax) bcnt_d = bcnt_q + 1'b1;
                rel = ~bus.m1_req | ~bus.m1_lock | (bcnt_q >= BurstLast & xfer1 & bus.m0_req);
                if (rel) begin
                    last_d  = 1'b1;
                    state_d = bus.m0_req ? StOwn0 : (bus.m1_req ? StOwn1 : StIdle);
                end
            end
            default: state_d = StIdle;
        endcase
        // Every new tenure, including re-entry by the same master, starts a fresh count
        if (state_d != StIdle && (state_q == StIdle || rel)) bcnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            bcnt_q    <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            owner_q   <= 2'b00;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            bcnt_q    <= bcnt_d;
            gnt0_q    <= (state_d == StOwn0);
            gnt1_q    <= (state_d == StOwn1);
            owner_q   <= {state_d == StOwn1, state_d == StOwn0};
            rvalid0_q <= xfer0 & ~bus.m0_we;
            rvalid1_q <= xfer1 & ~bus.m1_we;
        end
    end

    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_adr   = adr_hold_q;
        sram_wdata = wdata_hold_q;
        if (gnt0_q) begin
            sram_cs    = bus.m0_req;
            sram_we    = bus.m0_req & bus.m0_we;
            sram_adr   = bus.m0_adr[SRAM_AW+1:2];
            sram_wdata = bus.m0_wdata;
        end else if (gnt1_q) begin
            sram_cs    = bus.m1_req;
            sram_we    = bus.m1_req & bus.m1_we;
            sram_adr   = bus.m1_adr[SRAM_AW+1:2];
            sram_wdata = bus.m1_wdata;
        end
    end

    // Keeps the SRAM address/data lines quiet while idle
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            adr_hold_q   <= '0;
            wdata_hold_q <= '0;
        end else if (gnt0_q || gnt1_q) begin
            adr_hold_q   <= sram_adr;
            wdata_hold_q <= sram_wdata;
        end
    end

    assign bus.m0_gnt     = gnt0_q;
    assign bus.m1_gnt     = gnt1_q;
    assign bus.m0_rvalid  = rvalid0_q;
    assign bus.m1_rvalid  = rvalid1_q;
    assign bus.owner      = owner_q;
    assign bus.rdata      = bus.sram_rdata;
    assign bus.sram_cs    = sram_cs;
    assign bus.sram_we    = sram_we;
    assign bus.sram_adr   = sram_adr;
    assign bus.sram_wdata = sram_wdata;

    // Byte-lane and upper address bits play no part in a word access
    logic unused_adr;
    assign unused_adr = ^{bus.m0_adr[1:0], bus.m0_adr[WIDTH-1:SRAM_AW+2],
                          bus.m1_adr[1:0], bus.m1_adr[WIDTH-1:SRAM_AW+2]};
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written burst,
// lock and reset sequences against a small behavioural SRAM.
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(W), .SRAM_AW(AW)) bus ();

    mem_arbiter #(.WIDTH(W), .SRAM_AW(AW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset_(reset_),
        .bus   (bus)
    );

    // SRAM model: write commits at the edge, read data valid the cycle after
    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (bus.sram_we) mem[bus.sram_adr] <= bus.sram_wdata;
            else             rd_q <= mem[bus.sram_adr];
        end
    end
    assign bus.sram_rdata = rd_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  m0;     // {req, lock, we}
        logic [31:0] a0, d0;
        logic [2:0]  m1;
        logic [31:0] a1, d1;
        logic [5:0]  flg;    // expected {gnt0, gnt1, rvalid0, rvalid1, sram_cs, sram_we}
        logic [7:0]  eadr;
        logic [1:0]  eown;
        logic        ckrd;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t v(input logic [2:0] m0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [2:0] m1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic [5:0] flg, input logic [7:0] eadr,
                               input logic [1:0] eown, input logic ckrd, input logic [31:0] erd);
        vec_t r;
        r.m0 = m0; r.a0 = a0; r.d0 = d0; r.m1 = m1; r.a1 = a1; r.d1 = d1;
        r.flg = flg; r.eadr = eadr; r.eown = eown; r.ckrd = ckrd; r.erd = erd;
        return r;
    endfunction

    vec_t tbl[14];
    int n1, n1_at_m0, rv1n, n0, first_c, last_c;
    logic m0_done, check_regain, found;

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        mem[5] = 32'h2007_0005;
        mem[6] = 32'h2007_0006;
        {bus.m0_req, bus.m0_lock, bus.m0_we} = 3'b000;
        {bus.m1_req, bus.m1_lock, bus.m1_we} = 3'b000;
        bus.m0_adr = '0; bus.m0_wdata = '0; bus.m1_adr = '0; bus.m1_wdata = '0;

        // read word 5, idle, write word 5, idle, tie-driven alternation (m1 first: m0 owned last)
        tbl[0]  = v(3'b100, 32'h14, 0, 3'b000, 32'h18, 0, 6'b000000, 8'd0, 2'b00, 0, 0);
        tbl[1]  = v(3'b100, 32'h14, 0, 3'b000, 32'h18, 0, 6'b100010, 8'd5, 2'b01, 0, 0);
        tbl[2]  = v(3'b000, 32'h14, 0, 3'b000, 32'h18, 0, 6'b101000, 8'd5, 2'b01, 1, 32'h2007_0005);
        tbl[3]  = v(3'b000, 32'h14, 0, 3'b000, 32'h18, 0, 6'b000000, 8'd5, 2'b00, 0, 0);
        tbl[4]  = v(3'b101, 32'd20, 7, 3'b000, 32'h18, 0, 6'b000000, 8'd5, 2'b00, 0, 0);
        tbl[5]  = v(3'b101, 32'd20, 7, 3'b000, 32'h18, 0, 6'b100011, 8'd5, 2'b01, 0, 0);
        tbl[6]  = v(3'b001, 32'd20, 7, 3'b000, 32'h18, 0, 6'b100000, 8'd5, 2'b01, 0, 0);
        tbl[7]  = v(3'b000, 32'd20, 7, 3'b000, 32'h18, 0, 6'b000000, 8'd5, 2'b00, 0, 0);
        tbl[8]  = v(3'b100, 32'h14, 0, 3'b100, 32'h18, 0, 6'b000000, 8'd5, 2'b00, 0, 0);
        tbl[9]  = v(3'b100, 32'h14, 0, 3'b100, 32'h18, 0, 6'b010010, 8'd6, 2'b10, 0, 0);
        tbl[10] = v(3'b100, 32'h14, 0, 3'b100, 32'h18, 0, 6'b100110, 8'd5, 2'b01, 1, 32'h2007_0006);
        tbl[11] = v(3'b100, 32'h14, 0, 3'b100, 32'h18, 0, 6'b011010, 8'd6, 2'b10, 1, 32'd7);
        tbl[12] = v(3'b000, 32'h14, 0, 3'b000, 32'h18, 0, 6'b100100, 8'd5, 2'b01, 1, 32'h2007_0006);
        tbl[13] = v(3'b000, 32'h14, 0, 3'b000, 32'h18, 0, 6'b000000, 8'd5, 2'b00, 0, 0);

        #3;
        chk("reset_state", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                            bus.sram_cs, bus.sram_we, bus.owner}, 8'h00);
        repeat (2) @(negedge clk);
        reset_ = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            {bus.m0_req, bus.m0_lock, bus.m0_we} = tbl[i].m0;
            bus.m0_adr = tbl[i].a0; bus.m0_wdata = tbl[i].d0;
            {bus.m1_req, bus.m1_lock, bus.m1_we} = tbl[i].m1;
            bus.m1_adr = tbl[i].a1; bus.m1_wdata = tbl[i].d1;
            #4;
            chk($sformatf("vec%0d_ctl", i),
                {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.sram_cs, bus.sram_we,
                 bus.sram_adr, bus.owner},
                {tbl[i].flg, tbl[i].eadr, tbl[i].eown});
            if (tbl[i].ckrd) chk($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].erd);
            if (tbl[i].flg[0])
                chk($sformatf("vec%0d_wdata", i), bus.sram_wdata,
                    tbl[i].flg[5] ? tbl[i].d0 : tbl[i].d1);
        end
        chk("mem5_written", mem[5], 32'd7);

        // m1 locked burst of 10 reads against a waiting m0
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_adr = 32'h14;
        bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_we = 1'b0; bus.m1_adr = 32'h18;
        n1 = 0; n1_at_m0 = -1; rv1n = 0; m0_done = 1'b0; check_regain = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (n1 == 10) begin bus.m1_req = 1'b0; bus.m1_lock = 1'b0; end
            if (m0_done) bus.m0_req = 1'b0;
            #4;
            if (check_regain) begin
                chk("burst_m1_regain", bus.m1_gnt, 1'b1);
                check_regain = 1'b0;
            end
            if (bus.m1_rvalid) rv1n++;
            if (bus.m1_req && bus.m1_gnt) n1++;
            if (bus.m0_req && bus.m0_gnt && !m0_done) begin
                n1_at_m0 = n1; m0_done = 1'b1; check_regain = 1'b1;
            end
        end
        chk("burst_m1_before_m0", n1_at_m0, 4);
        chk("burst_m1_total", n1, 10);
        chk("burst_m1_rvalids", rv1n, 10);

        // m0 locked writes alone: no cap without a competitor
        bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_we = 1'b1;
        bus.m0_adr = 32'h20; bus.m0_wdata = 32'hA5;
        n0 = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20 && n0 < 8; c++) begin
            @(posedge clk); #5;
            if (bus.m0_req && bus.m0_gnt) begin
                n0++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        chk("lock_m0_xfers", n0, 8);
        chk("lock_m0_continuous", last_c - first_c + 1, 8);
        @(posedge clk); #1;
        bus.m0_req = 1'b0; bus.m0_lock = 1'b0;
        #4;
        chk("lock_drop_cycle", {bus.m0_gnt, bus.sram_cs}, 2'b10);
        @(posedge clk); #5;
        chk("lock_then_idle", {bus.owner, bus.m0_gnt}, 3'b000);
        chk("mem8_written", mem[8], 32'hA5);

        // reset mid-burst with a read return pending
        bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_we = 1'b0; bus.m1_adr = 32'h18;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(posedge clk); #5;
            if (bus.m1_req && bus.m1_gnt) found = 1'b1;
        end
        chk("rst_burst_started", found, 1'b1);
        @(posedge clk); #1;
        chk("rst_pre_rvalid", bus.m1_rvalid, 1'b1);
        bus.m0_req = 1'b1; bus.m1_lock = 1'b0;
        reset_ = 1'b0;
        #1;
        chk("rst_async_clear", {bus.m0_gnt, bus.m1_gnt, bus.sram_cs, bus.m0_rvalid,
                                bus.m1_rvalid, bus.owner}, 7'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_held_no_rvalid", {bus.m1_rvalid, bus.m1_gnt}, 2'b00);
        reset_ = 1'b1;
        @(posedge clk); #5;
        chk("rst_tie_to_m0", {bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid, bus.owner}, 5'b10001);

        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
